button_event_decoder: RTL and testbench

//  Consumer of a debounced button level: classifies each press into one-cycle

---
 rtl/button_event_decoder_pkg.sv | 35 +++
 rtl/button_unit_timer.sv | 37 +++
 rtl/button_event_decoder.sv | 131 +++++++++++++
 tb/tb_button_event_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared types and width helpers for the button event decoder.
package button_event_decoder_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE         = 3'd0,
    ST_PRESSED      = 3'd1,
    ST_LONG_HELD    = 3'd2,
    ST_WAIT_SECOND  = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_t;

  // Registered output bundle: four one-cycle event pulses plus the held level.
  typedef struct packed {
    logic press_short;
    logic press_double;
    logic press_long;
    logic press_repeat;
    logic held;
  } events_t;

  // Prescaler width; a divide-by-one prescaler still needs one bit.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_unit_timer.sv
// Prescaler plus unit counter; restart clears both so thresholds count from state entry.
module button_unit_timer #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned PRESC_W  = 17,
  parameter int unsigned UNIT_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  output logic              tick_c,
  output logic [UNIT_W-1:0] units
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;

  // Unit tick fires in the last prescaler cycle of each unit.
  assign tick_c = (presc == PRESC_LAST);

  // Prescaler wraps on tick; unit counter advances on tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      units <= '0;
    end else if (restart) begin
      presc <= '0;
      units <= '0;
    end else if (tick_c) begin
      presc <= '0;
      units <= units + UNIT_W'(1);
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into short/double/long/repeat pulses.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned LONG_MS   = 800,
  parameter int unsigned REPEAT_MS = 200,
  parameter int unsigned DOUBLE_MS = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_short,
  output logic press_double,
  output logic press_long,
  output logic press_repeat,
  output logic held
);

  localparam int unsigned PRESC_W = presc_width(TICK_DIV);
  localparam int unsigned UNIT_W  = $clog2(max3(LONG_MS, REPEAT_MS, DOUBLE_MS)) + 1;

  // A threshold of N units is hit on the tick that completes unit N-1.
  localparam logic [UNIT_W-1:0] LONG_LAST   = UNIT_W'(LONG_MS - 1);
  localparam logic [UNIT_W-1:0] REPEAT_LAST = UNIT_W'(REPEAT_MS - 1);
  localparam logic [UNIT_W-1:0] DOUBLE_LAST = UNIT_W'(DOUBLE_MS - 1);

  state_t              state, state_next;
  events_t             ev_q, ev_next;
  logic                btn_q;
  logic                armed;
  logic                rise_c, fall_c;
  logic                restart_c;
  logic                tick_c;
  logic [UNIT_W-1:0]   units;

  // A level already high at reset release must not count as a press.
  assign rise_c = btn & ~btn_q & armed;
  assign fall_c = ~btn & btn_q;

  // Edge-detect register; armed once the button has been seen released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      btn_q <= btn;
      armed <= armed | ~btn;
    end
  end

  button_unit_timer #(
    .TICK_DIV (TICK_DIV),
    .PRESC_W  (PRESC_W),
    .UNIT_W   (UNIT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick_c  (tick_c),
    .units   (units)
  );

  // State register and registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      ev_q  <= '0;
    end else begin
      state <= state_next;
      ev_q  <= ev_next;
    end
  end

  // Next-state, event decode and timer restart.
  always_comb begin
    state_next = state;
    ev_next    = '0;
    restart_c  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rise_c) state_next = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (fall_c) begin
          if (DOUBLE_MS == 0) begin
            ev_next.press_short = 1'b1;
            state_next          = ST_IDLE;
          end else begin
            state_next = ST_WAIT_SECOND;
          end
        end else if (tick_c && units == LONG_LAST) begin
          ev_next.press_long = 1'b1;
          state_next         = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (fall_c) begin
          state_next = ST_IDLE;
        end else if (tick_c && units == REPEAT_LAST) begin
          ev_next.press_repeat = 1'b1;
          restart_c            = 1'b1;
        end
      end
      ST_WAIT_SECOND: begin
        if (rise_c) begin
          ev_next.press_double = 1'b1;
          state_next           = ST_WAIT_RELEASE;
        end else if (tick_c && units == DOUBLE_LAST) begin
          ev_next.press_short = 1'b1;
          state_next          = ST_IDLE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (fall_c) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    ev_next.held = (state_next == ST_LONG_HELD);
    // Untimed states keep the timer parked at zero.
    if (state_next != state || state == ST_IDLE || state == ST_WAIT_RELEASE)
      restart_c = 1'b1;
  end

  assign press_short  = ev_q.press_short;
  assign press_double = ev_q.press_double;
  assign press_long   = ev_q.press_long;
  assign press_repeat = ev_q.press_repeat;
  assign held         = ev_q.held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: cycle-time reference model plus directed literal checks.
module tb_button_event_decoder;

  localparam int TD  = 4;
  localparam int LMS = 5;
  localparam int RMS = 2;
  localparam int DMS = 3;

  localparam int P_IDLE = 0, P_DOWN = 1, P_HELD = 2, P_GAP = 3, P_SECOND = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic press_short, press_double, press_long, press_repeat, held;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state: phase plus cycles elapsed in it
  int   phase = P_IDLE;
  int   t     = 0;
  logic pb    = 1'b0;
  logic arm   = 1'b0;
  logic [4:0] exp_v = '0;

  // pulse tallies seen on the DUT
  int n_short, n_double, n_long, n_rep, n_held;
  int last_short, last_double, last_long, first_rep, last_rep;

  button_event_decoder #(
    .TICK_DIV  (TD),
    .LONG_MS   (LMS),
    .REPEAT_MS (RMS),
    .DOUBLE_MS (DMS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .press_short  (press_short),
    .press_double (press_double),
    .press_long   (press_long),
    .press_repeat (press_repeat),
    .held         (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic clear_tally();
    n_short = 0; n_double = 0; n_long = 0; n_rep = 0; n_held = 0;
    last_short = -1; last_double = -1; last_long = -1; first_rep = -1; last_rep = -1;
  endtask

  // Drive btn=b for n cycles; start is the first cycle carrying the new level.
  task automatic drive(input logic b, input int n, output int start);
    @(posedge clk); #1;
    start = cyc;
    btn   = b;
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] nxt;
    logic rise, fall;
    int   np;
    got = {press_short, press_double, press_long, press_repeat, held};
    if (got[4]) begin n_short++;  last_short  = cyc; end
    if (got[3]) begin n_double++; last_double = cyc; end
    if (got[2]) begin n_long++;   last_long   = cyc; end
    if (got[1]) begin n_rep++; if (first_rep < 0) first_rep = cyc; last_rep = cyc; end
    if (got[0]) n_held++;
    n_checks++;
    if (!rst) begin
      if (got !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got s/d/l/r/h=%b required 00000", cyc, got);
      end
      phase = P_IDLE; t = 0; pb = 1'b0; arm = 1'b0; exp_v = '0;
    end else begin
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got s/d/l/r/h=%b required %b", cyc, got, exp_v);
      end
      rise = btn && !pb && arm;
      fall = !btn && pb;
      nxt  = '0;
      np   = phase;
      case (phase)
        P_IDLE:   if (rise) np = P_DOWN;
        P_DOWN: begin
          if (fall) np = P_GAP;
          else if (t == LMS*TD - 1) begin nxt[2] = 1'b1; np = P_HELD; end
        end
        P_HELD: begin
          if (fall) np = P_IDLE;
          else if (t % (RMS*TD) == RMS*TD - 1) nxt[1] = 1'b1;
        end
        P_GAP: begin
          if (rise) begin nxt[3] = 1'b1; np = P_SECOND; end
          else if (t == DMS*TD - 1) begin nxt[4] = 1'b1; np = P_IDLE; end
        end
        default:  if (fall) np = P_IDLE;
      endcase
      t     = (np == phase) ? t + 1 : 0;
      phase = np;
      nxt[0] = (phase == P_HELD);
      exp_v = nxt;
      arm   = arm | !btn;
      pb    = btn;
    end
  end

  initial begin
    int r, d;
    clear_tally();
    // reset held with button toggling
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; btn = ~btn;
    end
    @(posedge clk); #1; btn = 1'b1;
    check_int("in_reset_pulses", n_short + n_double + n_long + n_rep + n_held, 0);
    // release with button already high: no press recognised
    rst = 1'b1;
    clear_tally();
    drive(1'b1, 40, r);
    check_int("high_at_release_events", n_short + n_double + n_long + n_rep + n_held, 0);
    drive(1'b0, 20, d);

    // single short press
    clear_tally();
    drive(1'b1, 8, r);
    drive(1'b0, 30, d);
    check_int("short_count", n_short, 1);
    check_int("short_cycle", last_short - r, 21);
    check_int("short_others", n_double + n_long + n_rep + n_held, 0);

    // double press, second press held long
    clear_tally();
    drive(1'b1, 4, r);
    drive(1'b0, 6, d);
    drive(1'b1, 30, d);
    drive(1'b0, 30, d);
    check_int("double_count", n_double, 1);
    check_int("double_cycle", last_double - r, 11);
    check_int("double_others", n_short + n_long + n_rep + n_held, 0);

    // long press with auto-repeat
    clear_tally();
    drive(1'b1, 40, r);
    drive(1'b0, 30, d);
    check_int("long_cycle", last_long - r, 21);
    check_int("long_count", n_long, 1);
    check_int("repeat_count", n_rep, 2);
    check_int("repeat_first", first_rep - r, 29);
    check_int("repeat_second", last_rep - r, 37);
    check_int("held_cycles", n_held, 20);
    check_int("long_no_short", n_short + n_double, 0);

    // release exactly on the long threshold: short path wins
    clear_tally();
    drive(1'b1, 20, r);
    drive(1'b0, 30, d);
    check_int("fall_at_long_no_long", n_long + n_held, 0);
    check_int("fall_at_long_short", last_short - r, 33);

    // second rise exactly on the double timeout: double wins
    clear_tally();
    drive(1'b1, 4, r);
    drive(1'b0, 12, d);
    drive(1'b1, 3, d);
    drive(1'b0, 30, d);
    check_int("rise_at_timeout_double", last_double - r, 17);
    check_int("rise_at_timeout_no_short", n_short, 0);

    // reset mid-hold drops held at once and swallows everything after
    clear_tally();
    drive(1'b1, 25, r);
    check_int("held_before_reset", held, 1);
    rst = 1'b0;
    #1;
    check_int("held_async_reset", held, 0);
    drive(1'b1, 3, d);
    rst = 1'b1;
    clear_tally();
    drive(1'b1, 30, d);
    check_int("after_reset_events", n_short + n_double + n_long + n_rep + n_held, 0);
    drive(1'b0, 20, d);

    // randomized traffic against the model
    for (int i = 0; i < 260; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(posedge clk); #1;
        rst = 1'b0;
        btn = 1'($urandom_range(0, 1));
        drive(btn, int'($urandom_range(1, 3)), d);
        rst = 1'b1;
      end else begin
        drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)), d);
      end
    end
    drive(1'b0, 30, d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
